snn_lif_layer: RTL and testbench

Parametrised single-layer spiking network. Multi-channel delta-modulation encoders feed a layer of leaky integrate-and-fire neurons through a runtime-writable signed weight matrix. A winner-take-all stage selects the firing neuron, with lateral inhibition and per-neuron refractory periods. The block succeeds the single-channel, 2-bit-weight, non-leaky network as the top-level classifier core between the ECG sample source and the output logic.

---
 rtl/snn_lif_layer_if.sv | 15 +
 rtl/snn_lif_layer.sv | 179 +++++++++++++++++
 tb/tb_snn_lif_layer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_lif_layer_if.sv
`default_nettype none
// snn_lif_layer_if: runtime weight-write handshake into the LIF layer.
interface snn_lif_layer_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int W_WIDTH    = 4
);
  logic                      wr_valid_i;
  logic                      wr_ready_o;
  logic [ADDR_WIDTH-1:0]     wr_addr_i;
  logic signed [W_WIDTH-1:0] wr_data_i;

  modport master (output wr_valid_i, output wr_addr_i, output wr_data_i, input wr_ready_o);
  modport slave  (input wr_valid_i, input wr_addr_i, input wr_data_i, output wr_ready_o);
endinterface
`default_nettype wire

// File: rtl/snn_lif_layer.sv
`default_nettype none
// snn_lif_layer: delta-modulation encoders driving a leaky integrate-and-fire layer
// with winner-take-all, lateral inhibition and refractory periods.
module snn_lif_layer #(
  parameter int NUM_IN       = 1,
  parameter int NUM_NODES    = 4,
  parameter int SAMPLE_WIDTH = 32,
  parameter int W_WIDTH      = 4,
  parameter int V_WIDTH      = 16,
  parameter int CLK_DIV      = 1200000,
  parameter int THRESHOLD    = 64,
  parameter int LEAK_SHIFT   = 4,
  parameter int REFRACT      = 3
) (
  input  wire logic                                 clk_i,
  input  wire logic                                 rst_ni,
  input  wire logic [NUM_IN*SAMPLE_WIDTH-1:0]       sample_i,
  input  wire logic [SAMPLE_WIDTH-1:0]              delta_i,
  snn_lif_layer_if.slave                            wr,
  output logic                                      tick_o,
  output logic                                      spike_o,
  output logic [(NUM_NODES > 1 ? $clog2(NUM_NODES) : 1)-1:0] winner_o
);

  localparam int LINES = 2 * NUM_IN;
  localparam int DEPTH = NUM_NODES * LINES;
  localparam int WIN_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int RC_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int SW1   = SAMPLE_WIDTH + 1;
  localparam int ACC_W = V_WIDTH + W_WIDTH + $clog2(LINES) + 2;

  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic signed [ACC_W-1:0]   ACC_MAX  = ACC_W'((2 ** (V_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0]   ACC_MIN  = ACC_W'(-(2 ** (V_WIDTH - 1)));
  localparam logic signed [V_WIDTH-1:0] THR      = V_WIDTH'(THRESHOLD);
  localparam logic [RC_W-1:0]           RC_LOAD  = RC_W'(REFRACT);

  logic [CNT_W-1:0] cnt;
  logic             first;
  logic             upd;
  logic [LINES-1:0] lines;

  logic signed [W_WIDTH-1:0] w      [DEPTH];
  logic signed [V_WIDTH-1:0] v      [NUM_NODES];
  logic [RC_W-1:0]           rc     [NUM_NODES];
  logic signed [V_WIDTH-1:0] v_next [NUM_NODES];
  logic [NUM_NODES-1:0]      cand;
  logic signed [V_WIDTH-1:0] leak;
  logic signed [ACC_W-1:0]   acc;
  logic                      any;
  logic [WIN_W-1:0]          win;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_o = (cnt == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first <= 1'b1;
      upd   <= 1'b0;
    end else begin
      upd <= tick_o;
      if (tick_o) first <= 1'b0;
    end
  end

  for (genvar c = 0; c < NUM_IN; c++) begin : g_enc
    logic signed [SAMPLE_WIDTH-1:0] smp;
    logic signed [SAMPLE_WIDTH-1:0] ref_val;
    logic signed [SW1-1:0]          diff;
    logic signed [SW1-1:0]          step;
    logic                           up;
    logic                           dn;
    logic                           up_q;
    logic                           dn_q;

    assign smp  = sample_i[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    // One extra bit keeps the difference of two full-range samples exact.
    assign diff = SW1'(smp) - SW1'(ref_val);
    assign step = {1'b0, delta_i};
    assign up   = (diff >= step);
    assign dn   = (-diff >= step);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ref_val <= '0;
        up_q    <= 1'b0;
        dn_q    <= 1'b0;
      end else begin
        up_q <= tick_o && !first && up;
        dn_q <= tick_o && !first && !up && dn;
        if (tick_o) begin
          if (first)   ref_val <= smp;
          else if (up) ref_val <= ref_val + delta_i;
          else if (dn) ref_val <= ref_val - delta_i;
        end
      end
    end

    assign lines[2*c]   = up_q;
    assign lines[2*c+1] = dn_q;
  end

  // Writes are refused only while the neuron update reads the weights.
  assign wr.wr_ready_o = !upd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) w[i] <= '0;
    end else if (wr.wr_valid_i && !upd && (32'(wr.wr_addr_i) < DEPTH)) begin
      w[wr.wr_addr_i] <= wr.wr_data_i;
    end
  end

  always_comb begin
    leak = '0;
    acc  = '0;
    for (int n = 0; n < NUM_NODES; n++) begin
      leak = v[n] >>> LEAK_SHIFT;
      acc  = ACC_W'(v[n]) - ACC_W'(leak);
      for (int l = 0; l < LINES; l++) begin
        if (lines[l]) acc = acc + ACC_W'(w[n*LINES + l]);
      end
      if (acc > ACC_MAX)      v_next[n] = V_WIDTH'(ACC_MAX);
      else if (acc < ACC_MIN) v_next[n] = V_WIDTH'(ACC_MIN);
      else                    v_next[n] = V_WIDTH'(acc);
      cand[n] = (rc[n] == '0) && (v_next[n] >= THR);
    end
  end

  always_comb begin
    any = 1'b0;
    win = '0;
    for (int n = NUM_NODES - 1; n >= 0; n--) begin
      if (cand[n]) begin
        any = 1'b1;
        win = WIN_W'(n);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spike_o  <= 1'b0;
      winner_o <= '0;
      for (int n = 0; n < NUM_NODES; n++) begin
        v[n]  <= '0;
        rc[n] <= '0;
      end
    end else begin
      spike_o <= upd && any;
      if (upd) begin
        if (any) winner_o <= win;
        for (int n = 0; n < NUM_NODES; n++) begin
          if (rc[n] != '0) begin
            v[n]  <= '0;
            rc[n] <= rc[n] - RC_W'(1);
          end else if (any) begin
            v[n] <= '0;
            if (win == WIN_W'(n)) rc[n] <= RC_LOAD;
          end else begin
            v[n] <= v_next[n];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snn_lif_layer.sv
`default_nettype none
// tb_snn_lif_layer: directed self-checking bench for the LIF layer (2 channels, 2 neurons, CLK_DIV=4).
module tb_snn_lif_layer;

  localparam int SW = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic signed [SW-1:0] s0 = '0;
  logic signed [SW-1:0] s1 = '0;
  logic [SW-1:0]        delta = 16'd5;
  logic                 tick_o;
  logic                 spike_o;
  logic [0:0]           winner_o;
  logic [3:0]           lines_t1;
  int                   checks = 0;
  int                   failures = 0;

  snn_lif_layer_if #(.ADDR_WIDTH(3), .W_WIDTH(5)) wr_if ();

  snn_lif_layer #(
    .NUM_IN(2), .NUM_NODES(2), .SAMPLE_WIDTH(SW), .W_WIDTH(5), .V_WIDTH(8),
    .CLK_DIV(4), .THRESHOLD(10), .LEAK_SHIFT(4), .REFRACT(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sample_i({s1, s0}), .delta_i(delta),
    .wr(wr_if), .tick_o(tick_o), .spike_o(spike_o), .winner_o(winner_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion within 2 ms");
    $fatal(1);
  end

  task automatic apply_reset();
    rst_ni = 1'b0;
    s0 = '0;
    s1 = '0;
    wr_if.wr_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk_i);
      seen = tick_o;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL tick_timeout: got no tick_o expected one within 8 cycles");
    end
  endtask

  // Leaves the bench at the negedge of T+2, where spike_o/winner_o/V are valid.
  task automatic step(input logic signed [SW-1:0] a, input logic signed [SW-1:0] b);
    s0 = a;
    s1 = b;
    wait_tick();
    @(negedge clk_i);
    lines_t1 = dut.lines;
    @(negedge clk_i);
  endtask

  task automatic write_w(input logic [2:0] addr, input logic signed [4:0] data);
    wr_if.wr_valid_i = 1'b1;
    wr_if.wr_addr_i  = addr;
    wr_if.wr_data_i  = data;
    for (int i = 0; i < 4 && !wr_if.wr_ready_o; i++) @(negedge clk_i);
    if (!wr_if.wr_ready_o) begin
      checks++; failures++;
      $display("FAIL write_timeout: got wr_ready_o=0 expected 1 within 4 cycles");
    end
    @(negedge clk_i);
    wr_if.wr_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_tick;
    rst_ni = 1'b0;
    wr_if.wr_valid_i = 1'b0;
    wr_if.wr_addr_i = '0;
    wr_if.wr_data_i = '0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (tick_o !== 1'b0 || spike_o !== 1'b0 || winner_o !== 1'b0 || wr_if.wr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: got tick=%b spike=%b winner=%b ready=%b expected 0 0 0 1",
               tick_o, spike_o, winner_o, wr_if.wr_ready_o);
    end
    rst_ni = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) @(negedge clk_i);
      exp_tick = (cyc % 4 == 0);
      checks++;
      if (tick_o !== exp_tick) begin
        failures++;
        $display("FAIL tick_cycle_%0d: got %b expected %b", cyc, tick_o, exp_tick);
      end
    end
  endtask

  task automatic test_encoder();
    logic signed [SW-1:0] smp [4] = '{16'sd0, 16'sd7, 16'sd7, 16'sd0};
    logic [1:0]           exp [4] = '{2'b00, 2'b01, 2'b00, 2'b10};
    apply_reset();
    delta = 16'd5;
    for (int i = 0; i < 4; i++) begin
      step(smp[i], 16'sd0);
      checks++;
      if (lines_t1[1:0] !== exp[i]) begin
        failures++;
        $display("FAIL encoder_ch0_%0d: got %b expected %b", i, lines_t1[1:0], exp[i]);
      end
      checks++;
      if (lines_t1[3:2] !== 2'b00) begin
        failures++;
        $display("FAIL encoder_ch1_%0d: got %b expected 00", i, lines_t1[3:2]);
      end
    end
  endtask

  task automatic test_fire();
    apply_reset();
    write_w(3'd0, 5'sd6);
    write_w(3'd4, 5'sd3);
    step(16'sd0, 16'sd0);
    step(16'sd5, 16'sd0);
    checks++;
    if (dut.v[0] !== 8'sd6 || dut.v[1] !== 8'sd3 || spike_o !== 1'b0) begin
      failures++;
      $display("FAIL fire_first: got v0=%0d v1=%0d spike=%b expected 6 3 0", dut.v[0], dut.v[1], spike_o);
    end
    step(16'sd10, 16'sd0);
    checks++;
    if (spike_o !== 1'b1 || winner_o !== 1'b0) begin
      failures++;
      $display("FAIL fire_spike: got spike=%b winner=%0d expected 1 0", spike_o, winner_o);
    end
    checks++;
    if (dut.v[0] !== 8'sd0 || dut.v[1] !== 8'sd0) begin
      failures++;
      $display("FAIL fire_inhibit: got v0=%0d v1=%0d expected 0 0", dut.v[0], dut.v[1]);
    end
    @(negedge clk_i);
    checks++;
    if (spike_o !== 1'b0) begin
      failures++;
      $display("FAIL fire_pulse_width: got spike=%b expected 0", spike_o);
    end
  endtask

  task automatic test_refractory_tie();
    logic       exp_s [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [0:0] exp_w [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset();
    write_w(3'd0, 5'sd12);
    write_w(3'd4, 5'sd12);
    step(16'sd0, 16'sd0);
    for (int i = 0; i < 4; i++) begin
      step(SW'(5 * (i + 1)), 16'sd0);
      checks++;
      if (spike_o !== exp_s[i] || winner_o !== exp_w[i]) begin
        failures++;
        $display("FAIL tie_tick_%0d: got spike=%b winner=%0d expected %b %0d",
                 i, spike_o, winner_o, exp_s[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int exp_v [20] = '{-16, -31, -45, -58, -70, -81, -91, -101, -110, -119,
                       -127, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    logic signed [7:0] ev;
    apply_reset();
    write_w(3'd1, -5'sd8);
    write_w(3'd3, -5'sd8);
    step(16'sd0, 16'sd0);
    for (int i = 0; i < 20; i++) begin
      step(SW'(-5 * (i + 1)), SW'(-5 * (i + 1)));
      ev = 8'(exp_v[i]);
      checks++;
      if (dut.v[0] !== ev || spike_o !== 1'b0) begin
        failures++;
        $display("FAIL saturate_%0d: got v0=%0d spike=%b expected %0d 0", i, dut.v[0], spike_o, ev);
      end
    end
  endtask

  task automatic test_write_stall();
    apply_reset();
    write_w(3'd0, 5'sd3);
    step(16'sd0, 16'sd0);
    s0 = 16'sd5;
    wait_tick();
    @(negedge clk_i);
    checks++;
    if (wr_if.wr_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_ready_low: got %b expected 0", wr_if.wr_ready_o);
    end
    wr_if.wr_valid_i = 1'b1;
    wr_if.wr_addr_i  = 3'd0;
    wr_if.wr_data_i  = 5'sd7;
    @(negedge clk_i);
    checks++;
    if (wr_if.wr_ready_o !== 1'b1 || dut.w[0] !== 5'sd3 || dut.v[0] !== 8'sd3) begin
      failures++;
      $display("FAIL stall_hold: got ready=%b w0=%0d v0=%0d expected 1 3 3",
               wr_if.wr_ready_o, dut.w[0], dut.v[0]);
    end
    @(negedge clk_i);
    wr_if.wr_valid_i = 1'b0;
    checks++;
    if (dut.w[0] !== 5'sd7) begin
      failures++;
      $display("FAIL stall_landed: got w0=%0d expected 7", dut.w[0]);
    end
    step(16'sd10, 16'sd0);
    checks++;
    if (spike_o !== 1'b1 || winner_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_new_weight: got spike=%b winner=%0d expected 1 0", spike_o, winner_o);
    end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    write_w(3'd4, 5'sd12);
    step(16'sd0, 16'sd0);
    step(16'sd5, 16'sd0);
    checks++;
    if (spike_o !== 1'b1 || winner_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_prefire: got spike=%b winner=%0d expected 1 1", spike_o, winner_o);
    end
    step(16'sd10, 16'sd0);
    step(16'sd15, 16'sd0);
    checks++;
    if (spike_o !== 1'b0 || winner_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_refractory: got spike=%b winner=%0d expected 0 1", spike_o, winner_o);
    end
    s0 = 16'sd20;
    wait_tick();
    @(posedge clk_i);
    #2;
    checks++;
    if (wr_if.wr_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_update_cycle: got ready=%b expected 0", wr_if.wr_ready_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (tick_o !== 1'b0 || spike_o !== 1'b0 || winner_o !== 1'b0 || wr_if.wr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_async: got tick=%b spike=%b winner=%b ready=%b expected 0 0 0 1",
               tick_o, spike_o, winner_o, wr_if.wr_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (spike_o !== 1'b0 || dut.v[1] !== 8'sd0) begin
        failures++;
        $display("FAIL abort_quiet_%0d: got spike=%b v1=%0d expected 0 0", i, spike_o, dut.v[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_encoder();
    test_fire();
    test_refractory_tie();
    test_saturation();
    test_write_stall();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
